// File: rtl/seq_adder_pkg.sv
// Shared types and helpers for the sequential chunked adder.
package seq_adder_pkg;

  // Controller states; encodings are fixed so other blocks can decode them.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Width of a chunk index register; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/seq_adder_chunk_adder.sv
// CHUNK-bit combinational ripple adder: {cout, s} = a + b + cin.
module chunk_adder #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] i_a,
  input  logic [CHUNK-1:0] i_b,
  input  logic             i_cin,
  output logic [CHUNK-1:0] o_s,
  output logic             o_cout
);

  assign {o_cout, o_s} = {1'b0, i_a} + {1'b0, i_b} + {{CHUNK{1'b0}}, i_cin};

endmodule

// File: rtl/seq_adder.sv
// Multi-cycle WIDTH-bit adder, CHUNK bits per cycle, LSB chunk first.
// The carry between chunks is registered, so the combinational path is one
// CHUNK-bit ripple adder regardless of WIDTH.
// Optional feature: define SEQ_ADDER_OVF_EN to add the signed 'overflow' output.
module seq_adder
  import seq_adder_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
`ifdef SEQ_ADDER_OVF_EN
  ,
  output logic             overflow
`endif
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IW     = idx_width(NCHUNK);
  localparam logic [IW-1:0] LAST_IDX = IW'(NCHUNK - 1);

  // Reject widths that do not split evenly into chunks.
  if ((CHUNK < 1) || (WIDTH % CHUNK != 0)) begin : g_bad_cfg
    $error("seq_adder: WIDTH must be a non-zero multiple of CHUNK");
  end

  state_t r_state;
  state_t w_next;

  logic [IW-1:0]                  r_idx;
  logic [NCHUNK-1:0][CHUNK-1:0]   r_a;
  logic [NCHUNK-1:0][CHUNK-1:0]   r_b;
  logic [NCHUNK-1:0][CHUNK-1:0]   r_sum;
  logic                           r_carry;
  logic                           r_cout;

  logic [CHUNK-1:0] w_s;
  logic             w_cout;
  logic             w_accept;
  logic             w_last;

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign w_accept  = in_valid && in_ready;
  assign w_last    = (r_idx == LAST_IDX);
  assign sum       = r_sum;
  assign carry_out = r_cout;

  // Single adder shared by all chunks; idx selects which slice it sees.
  chunk_adder #(.CHUNK(CHUNK)) u_chunk (
    .i_a    (r_a[r_idx]),
    .i_b    (r_b[r_idx]),
    .i_cin  (r_carry),
    .o_s    (w_s),
    .o_cout (w_cout)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Next-state: accept in IDLE, walk chunks in BUSY, hold in DONE until taken.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (in_valid)  w_next = BUSY;
      BUSY:    if (w_last)    w_next = DONE;
      DONE:    if (out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Operand capture and per-chunk accumulation; reset discards any partial sum.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
    end else if (w_accept) begin
      r_idx   <= '0;
      r_a     <= a;
      r_b     <= b;
      r_carry <= carry_in;
    end else if (r_state == BUSY) begin
      r_sum[r_idx] <= w_s;
      r_carry      <= w_cout;
      if (w_last) r_cout <= w_cout;
      else        r_idx  <= r_idx + 1'b1;
    end
  end

`ifdef SEQ_ADDER_OVF_EN
  logic r_ovf;
  assign overflow = r_ovf;

  // Signed overflow: operands agree in sign but the result's sign differs.
  // The top sum bit is the MSB of the chunk being written on the last edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_ovf <= 1'b0;
    else if ((r_state == BUSY) && w_last)
      r_ovf <= (r_a[NCHUNK-1][CHUNK-1] == r_b[NCHUNK-1][CHUNK-1]) &&
               (w_s[CHUNK-1] != r_a[NCHUNK-1][CHUNK-1]);
  end
`endif

endmodule

// File: tb/tb_seq_adder.sv
// Bench for seq_adder: a CHUNK=8 instance for directed cases and a CHUNK=32
// instance for single-cycle random traffic, both checked against a queue of
// expected results computed from a + b + cin.
module tb_seq_adder;

  typedef struct {
    logic [31:0] s;
    logic        c;
    logic        v;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic        in_valid, in_ready, out_valid, out_ready, carry_in, carry_out;
  logic [31:0] a, b, sum;
  logic        in_valid_w, in_ready_w, out_valid_w, out_ready_w, carry_in_w, carry_out_w;
  logic [31:0] a_w, b_w, sum_w;
`ifdef SEQ_ADDER_OVF_EN
  logic        overflow, overflow_w;
`endif

  seq_adder #(.WIDTH(32), .CHUNK(8)) u_dut8 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .carry_in(carry_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .carry_out(carry_out)
`ifdef SEQ_ADDER_OVF_EN
    , .overflow(overflow)
`endif
  );

  seq_adder #(.WIDTH(32), .CHUNK(32)) u_dut32 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid_w), .in_ready(in_ready_w),
    .a(a_w), .b(b_w), .carry_in(carry_in_w),
    .out_valid(out_valid_w), .out_ready(out_ready_w),
    .sum(sum_w), .carry_out(carry_out_w)
`ifdef SEQ_ADDER_OVF_EN
    , .overflow(overflow_w)
`endif
  );

  int   n_chk  = 0;
  int   n_fail = 0;
  exp_t q[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [31:0] ta, input logic [31:0] tb, input logic tc);
    exp_t        e;
    logic [32:0] t;
    t   = {1'b0, ta} + {1'b0, tb} + {32'd0, tc};
    e.s = t[31:0];
    e.c = t[32];
    e.v = (ta[31] == tb[31]) && (t[31] != ta[31]);
    return e;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Pop the oldest expectation and compare it with the CHUNK=8 outputs.
  task automatic pop_cmp8(input string tag);
    exp_t e;
    chk({tag, "_sb_depth"}, q.size(), 1);
    if (q.size() == 0) return;
    e = q.pop_front();
    chk({tag, "_sum"}, sum, e.s);
    chk({tag, "_cout"}, carry_out, e.c);
`ifdef SEQ_ADDER_OVF_EN
    chk({tag, "_ovf"}, overflow, e.v);
`endif
  endtask

  // Accept one operation on the CHUNK=8 instance, wait for it, check, drain.
  task automatic op8(input string tag, input logic [31:0] ta, input logic [31:0] tb, input logic tc);
    int n;
    n = 0;
    while (!in_ready && n < 20) begin tick; n++; end
    chk({tag, "_in_ready"}, in_ready, 1);
    a = ta; b = tb; carry_in = tc; in_valid = 1'b1;
    q.push_back(model(ta, tb, tc));
    tick;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin tick; n++; end
    chk({tag, "_latency"}, n, 4);
    pop_cmp8(tag);
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    chk({tag, "_in_ready_after"}, in_ready, 1);
    chk({tag, "_out_valid_after"}, out_valid, 0);
  endtask

  // Watchdog so a stuck handshake still ends the run.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   n;
    exp_t e;
    logic [31:0] ra, rb;
    logic        rc;

    rst = 1'b1;
    in_valid = 0; out_ready = 0; a = 0; b = 0; carry_in = 0;
    in_valid_w = 0; out_ready_w = 1; a_w = 0; b_w = 0; carry_in_w = 0;

    // Reset state, observed while reset is held and just after release.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", carry_out, 0);
    chk("rst_in_ready_w", in_ready_w, 1);
    chk("rst_out_valid_w", out_valid_w, 0);
`ifdef SEQ_ADDER_OVF_EN
    chk("rst_ovf", overflow, 0);
`endif
    rst = 1'b0;
    tick;
    chk("post_rst_in_ready", in_ready, 1);
    chk("post_rst_out_valid", out_valid, 0);

    // Directed sums.
    op8("carry_into_chunk1", 32'h000000FF, 32'h00000001, 1'b0);
    op8("ripple_all_chunks", 32'hFFFFFFFF, 32'h00000000, 1'b1);
    op8("pos_overflow",      32'h7FFFFFFF, 32'h00000001, 1'b0);
    op8("neg_overflow",      32'h80000000, 32'h80000000, 1'b0);
    op8("zero",              32'h00000000, 32'h00000000, 1'b0);
    op8("mixed",             32'h12345678, 32'h9ABCDEF0, 1'b1);

    // Back-pressure: result held while new operands are offered and ignored.
    a = 32'd5; b = 32'd6; carry_in = 1'b0; in_valid = 1'b1;
    q.push_back(model(32'd5, 32'd6, 1'b0));
    tick;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin tick; n++; end
    chk("stall_latency", n, 4);
    a = 32'h11111111; b = 32'h22222222; carry_in = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick;
      chk("stall_sum", sum, 32'd11);
      chk("stall_out_valid", out_valid, 1);
      chk("stall_in_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    pop_cmp8("stall");
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    chk("stall_in_ready_after", in_ready, 1);
    op8("after_stall", 32'h00000001, 32'h00000002, 1'b0);

    // Reset in the second BUSY cycle aborts and clears the partial sum.
    a = 32'h12345678; b = 32'h11111111; carry_in = 1'b0; in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    tick;
    #2 rst = 1'b1;
    #1;
    chk("abort_out_valid", out_valid, 0);
    chk("abort_sum", sum, 0);
    chk("abort_in_ready", in_ready, 1);
    chk("abort_cout", carry_out, 0);
    #2 rst = 1'b0;
    q.delete();
    tick;
    op8("after_abort", 32'd3, 32'd4, 1'b0);

    // A few random ops on the chunked instance.
    for (int i = 0; i < 20; i++)
      op8("rand8", $urandom, $urandom, 1'($urandom_range(0, 1)));

    // Single-chunk instance: back-to-back ops, out_ready held high.
    for (int i = 0; i < 1000; i++) begin
      case (i)
        0:       begin ra = 32'hFFFFFFFF; rb = 32'h0;        rc = 1'b1; end
        1:       begin ra = 32'h7FFFFFFF; rb = 32'h1;        rc = 1'b0; end
        2:       begin ra = 32'h80000000; rb = 32'h80000000; rc = 1'b0; end
        default: begin ra = $urandom;     rb = $urandom;     rc = 1'($urandom_range(0, 1)); end
      endcase
      n = 0;
      while (!in_ready_w && n < 10) begin tick; n++; end
      chk("w_in_ready", in_ready_w, 1);
      a_w = ra; b_w = rb; carry_in_w = rc; in_valid_w = 1'b1;
      q.push_back(model(ra, rb, rc));
      tick;
      in_valid_w = 1'b0;
      n = 0;
      while (!out_valid_w && n < 10) begin tick; n++; end
      chk("w_latency", n, 1);
      chk("w_sb_depth", q.size(), 1);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("w_sum", sum_w, e.s);
        chk("w_cout", carry_out_w, e.c);
`ifdef SEQ_ADDER_OVF_EN
        chk("w_ovf", overflow_w, e.v);
`endif
      end
      tick;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
